// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: one full-subtractor cell plus a borrow flop,
// producing one difference bit per clock (LSB first) under a start/busy/done handshake.
module serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf,
    output logic [1:0]   state_dbg
);

    localparam int          CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_res;
    logic          r_borrow;
    logic [CW-1:0] r_cnt;
    logic          r_a_msb;
    logic          r_b_msb;
    logic [N-1:0]  r_diff;
    logic          r_b_out;
    logic          r_ovf;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_bo;

    // Full-subtractor cell on the current LSBs and the carried-in borrow.
    assign w_x  = r_a_sh[0];
    assign w_y  = r_b_sh[0];
    assign w_d  = w_x ^ w_y ^ r_borrow;
    assign w_bo = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_b_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_res    <= {w_d, r_res[N-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Last bit: w_d is the result MSB, so publish directly from the cell.
                        r_state <= S_DONE;
                        r_diff  <= {w_d, r_res[N-1:1]};
                        r_b_out <= w_bo;
                        r_ovf   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (start) begin
                        r_state  <= S_RUN;
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_a_msb  <= a[N-1];
                        r_b_msb  <= b[N-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign ovf       = r_ovf;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_serial_sub.sv
// Randomized and directed checks of serial_sub at N=8 and N=4 against an
// integer-arithmetic reference, with a queue-based scoreboard and a negedge monitor.
module tb_serial_sub;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic [1:0] st8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;
  logic [1:0] st4;

  serial_sub #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8), .ovf(ovf8),
    .state_dbg(st8)
  );

  serial_sub #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bout4), .ovf(ovf4),
    .state_dbg(st4)
  );

  // Scoreboard: packed {diff[7:0], b_out, ovf}
  logic [9:0] exp8_q[$];
  logic [9:0] exp4_q[$];
  logic [9:0] held[2];
  int         busy_run[2];
  int         assert_cnt = 0;
  int         fail_cnt = 0;
  logic       mon_en = 1'b0;
  logic       rst_q = 1'b1;

  always @(posedge clk) rst_q <= reset;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] model(input int n, input int av, input int bv);
    int d, sa, sb, sd, half, full;
    logic [7:0] dm;
    logic bo, ov;
    full = 1 << n;
    half = full / 2;
    d    = av - bv;
    bo   = (d < 0);
    dm   = 8'((d + full) % full);
    sa   = (av >= half) ? av - full : av;
    sb   = (bv >= half) ? bv - full : bv;
    sd   = sa - sb;
    ov   = (sd >= half) || (sd < -half);
    return {dm, bo, ov};
  endfunction

  task automatic mon(input int idx, input int n, input logic dn, input logic bs,
                     input logic [7:0] df, input logic bo, input logic ov);
    logic [9:0] got, e;
    got = {df, bo, ov};
    if (rst_q) begin
      held[idx]     = '0;
      busy_run[idx] = 0;
    end
    if (dn && bs) chk($sformatf("busy_done_excl%0d", n), 32'(dn & bs), 32'd0);
    if (bs) busy_run[idx]++;
    if (dn) begin
      if ((idx == 0 ? exp8_q.size() : exp4_q.size()) == 0) begin
        chk($sformatf("unexpected_done%0d", n), 32'd1, 32'd0);
      end else begin
        e = (idx == 0) ? exp8_q.pop_front() : exp4_q.pop_front();
        chk($sformatf("result%0d", n), 32'(got), 32'(e));
        chk($sformatf("busy_len%0d", n), 32'(busy_run[idx]), 32'(n));
        held[idx] = e;
      end
      busy_run[idx] = 0;
    end else begin
      chk($sformatf("hold%0d", n), 32'(got), 32'(held[idx]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, 8, done8, busy8, diff8, bout8, ovf8);
      mon(1, 4, done4, busy4, {4'b0, diff4}, bout4, ovf4);
    end
  end

  task automatic drive(input int idx, input logic s, input logic [7:0] av, input logic [7:0] bv);
    if (idx == 0) begin
      start8 = s; a8 = av; b8 = bv;
    end else begin
      start4 = s; a4 = av[3:0]; b4 = bv[3:0];
    end
  endtask

  // One operation with fixed spec timing; noise toggles start/operands during RUN.
  task automatic run_op(input int idx, input int av, input int bv, input bit noise);
    int n;
    n = (idx == 0) ? 8 : 4;
    @(negedge clk);
    drive(idx, 1'b1, 8'(av), 8'(bv));
    if (idx == 0) exp8_q.push_back(model(n, av, bv));
    else          exp4_q.push_back(model(n, av, bv));
    repeat (n) begin
      @(negedge clk);
      drive(idx, noise ? 1'($urandom_range(0, 1)) : 1'b0,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    drive(idx, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    chk($sformatf("latency%0d", n), 32'(idx == 0 ? done8 : done4), 32'd1);
  endtask

  task automatic back_to_back();
    @(negedge clk);
    drive(0, 1'b1, 8'h10, 8'h01);
    exp8_q.push_back(model(8, 'h10, 'h01));
    repeat (8) begin
      @(negedge clk);
      drive(0, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    drive(0, 1'b1, 8'h00, 8'h00);
    chk("b2b_first_done", 32'(done8), 32'd1);
    exp8_q.push_back(model(8, 0, 0));
    repeat (8) begin
      @(negedge clk);
      drive(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00);
    chk("b2b_second_done", 32'(done8), 32'd1);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    drive(0, 1'b1, 8'hAA, 8'h55);
    repeat (3) begin
      @(negedge clk);
      drive(0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_bout", 32'(bout8), 32'd0);
    chk("abort_ovf", 32'(ovf8), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    held[0] = '0; held[1] = '0;
    busy_run[0] = 0; busy_run[1] = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_diff", 32'(diff8), 32'd0);
    chk("reset_bout", 32'(bout8), 32'd0);
    chk("reset_ovf", 32'(ovf8), 32'd0);

    run_op(0, 'h05, 'h03, 1'b0);
    run_op(0, 'h03, 'h05, 1'b1);
    run_op(0, 'h80, 'h01, 1'b1);
    run_op(0, 'h7F, 'hFF, 1'b0);
    repeat (3) @(negedge clk);
    back_to_back();
    repeat (2) @(negedge clk);
    reset_abort();
    run_op(0, 'hAA, 'h55, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        run_op(1, av, bv, 1'b0);
      end
    end

    repeat (12) @(negedge clk);
    chk("pending8", 32'(exp8_q.size()), 32'd0);
    chk("pending4", 32'(exp4_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
